// File: rtl/vga_sync_timing.sv
// VGA raster timing: turns PixelClock rising edges into H/V counters, sync pulses,
// display-enable window, pixel coordinates and line/frame start strobes.
module vga_sync_timing #(
  parameter int unsigned HVisible   = 640,
  parameter int unsigned HFront     = 16,
  parameter int unsigned HSyncLen   = 96,
  parameter int unsigned HBack      = 48,
  parameter int unsigned VVisible   = 480,
  parameter int unsigned VFront     = 10,
  parameter int unsigned VSyncLen   = 2,
  parameter int unsigned VBack      = 33,
  parameter int unsigned CountWidth = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  PixelClock,
  output logic                  HSync,
  output logic                  VSync,
  output logic                  DisplayEnable,
  output logic [CountWidth-1:0] PixelX,
  output logic [CountWidth-1:0] PixelY,
  output logic                  LineStart,
  output logic                  FrameStart
);

  localparam int unsigned HTotal      = HVisible + HFront + HSyncLen + HBack;
  localparam int unsigned VTotal      = VVisible + VFront + VSyncLen + VBack;
  localparam int unsigned HSyncStart  = HVisible + HFront;
  localparam int unsigned HSyncEnd    = HVisible + HFront + HSyncLen;
  localparam int unsigned VSyncStart  = VVisible + VFront;
  localparam int unsigned VSyncEnd    = VVisible + VFront + VSyncLen;

  logic                  pix_dly;
  logic                  tick;
  logic                  h_last;
  logic                  v_last;
  logic [CountWidth-1:0] h_count;
  logic [CountWidth-1:0] v_count;
  logic [31:0]           h_wide;
  logic [31:0]           v_wide;

  assign tick   = PixelClock & ~pix_dly;
  assign h_wide = 32'(h_count);
  assign v_wide = 32'(v_count);
  assign h_last = (h_wide == HTotal - 1);
  assign v_last = (v_wide == VTotal - 1);

  // pix_dly resets high so a PixelClock held high across reset release is not a tick
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pix_dly    <= 1'b1;
      h_count    <= '0;
      v_count    <= '0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      pix_dly    <= PixelClock;
      LineStart  <= tick & h_last;
      FrameStart <= tick & h_last & v_last;
      if (tick) begin
        if (h_last) begin
          h_count <= '0;
          v_count <= v_last ? '0 : v_count + CountWidth'(1);
        end else begin
          h_count <= h_count + CountWidth'(1);
        end
      end
    end
  end

  // Decodes straight from the counters so they never lag them
  always_comb begin
    HSync         = ~((h_wide >= HSyncStart) && (h_wide < HSyncEnd));
    VSync         = ~((v_wide >= VSyncStart) && (v_wide < VSyncEnd));
    DisplayEnable = (h_wide < HVisible) && (v_wide < VVisible);
    PixelX        = DisplayEnable ? h_count : '0;
    PixelY        = DisplayEnable ? v_count : '0;
  end

endmodule

// File: tb/tb_vga_sync_timing.sv
// Randomized bench for vga_sync_timing against a tick-count reference model,
// using a shrunken raster so whole frames fit in a short run.
module tb_vga_sync_timing;

  localparam int unsigned HV = 10, HF = 3, HS = 4, HB = 3;
  localparam int unsigned VV = 5,  VF = 2, VS = 2, VB = 3;
  localparam int unsigned CW = 6;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          PixelClock;
  logic          HSync, VSync, DisplayEnable, LineStart, FrameStart;
  logic [CW-1:0] PixelX, PixelY;

  vga_sync_timing #(
    .HVisible(HV), .HFront(HF), .HSyncLen(HS), .HBack(HB),
    .VVisible(VV), .VFront(VF), .VSyncLen(VS), .VBack(VB),
    .CountWidth(CW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(HSync), .VSync(VSync), .DisplayEnable(DisplayEnable),
    .PixelX(PixelX), .PixelY(PixelY),
    .LineStart(LineStart), .FrameStart(FrameStart)
  );

  always #5 Clock = ~Clock;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference: number of ticks since reset fully determines the raster position
  int unsigned n_ticks;
  logic        prev_pc;
  logic        exp_ls, exp_fs;
  int unsigned fs_seen;
  int unsigned div_ph;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d (tick %0d)", tag, got, exp, n_ticks);
    end
  endtask

  task automatic check_outputs();
    int unsigned h, v;
    logic de;
    h  = n_ticks % HT;
    v  = (n_ticks / HT) % VT;
    de = (h < HV) && (v < VV);
    check("hsync",  32'(HSync),         32'(!((h >= HV + HF) && (h < HV + HF + HS))));
    check("vsync",  32'(VSync),         32'(!((v >= VV + VF) && (v < VV + VF + VS))));
    check("de",     32'(DisplayEnable), 32'(de));
    check("pix_x",  32'(PixelX),        de ? h : 0);
    check("pix_y",  32'(PixelY),        de ? v : 0);
    check("line_start",  32'(LineStart),  32'(exp_ls));
    check("frame_start", 32'(FrameStart), 32'(exp_fs));
  endtask

  task automatic step(input logic rst, input logic pc);
    logic tk;
    @(negedge Clock);
    Reset      = rst;
    PixelClock = pc;
    @(posedge Clock);
    if (rst) begin
      n_ticks = 0;
      prev_pc = 1'b1;
      exp_ls  = 1'b0;
      exp_fs  = 1'b0;
    end else begin
      tk      = pc & ~prev_pc;
      prev_pc = pc;
      if (tk) n_ticks++;
      exp_ls = tk && (n_ticks % HT == 0);
      exp_fs = tk && (n_ticks % FT == 0);
    end
    #1;
    if (FrameStart === 1'b1) fs_seen++;
    check_outputs();
  endtask

  // Divider-like PixelClock: two cycles high, two low
  task automatic div_step(input logic rst);
    step(rst, (div_ph % 4) < 2);
    div_ph++;
  endtask

  initial begin
    int unsigned guard;
    n_ticks = 0; prev_pc = 1'b1; exp_ls = 1'b0; exp_fs = 1'b0;
    fs_seen = 0; div_ph = 0;
    Reset = 1'b1; PixelClock = 1'b1;

    repeat (3) step(1'b1, 1'b1);
    check("reset_hsync", 32'(HSync), 1);
    check("reset_de",    32'(DisplayEnable), 1);

    // Regular divider clock: just over one frame, one FrameStart expected
    fs_seen = 0;
    repeat (FT * 4 + 200) div_step(1'b0);
    check("frame_count", fs_seen, 1);

    // Random PixelClock with occasional resets
    repeat (2500) step(($urandom % 400) == 0, 1'(($urandom % 2)));

    // Freeze mid-line with PixelClock low, then resume
    repeat (37) div_step(1'b0);
    repeat (50) step(1'b0, 1'b0);
    repeat (60) div_step(1'b0);

    // Reset mid-frame for one cycle, then keep counting
    repeat (($urandom % FT) * 4) div_step(1'b0);
    step(1'b1, PixelClock);
    check("midreset_ls", 32'(LineStart), 0);
    repeat (100) div_step(1'b0);

    // Reset coincident with the final tick of a frame
    guard = 0;
    while (!((n_ticks % FT == FT - 1) && PixelClock == 1'b0) && guard < FT * 8) begin
      div_step(1'b0);
      guard++;
    end
    check("reach_frame_end", 32'(guard < FT * 8), 1);
    step(1'b1, 1'b1);
    check("reset_wins_fs", 32'(FrameStart), 0);
    step(1'b0, 1'b1);
    check("no_tick_on_release", 32'(PixelX), 0);
    div_ph = 2;
    repeat (200) div_step(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
